// File: rtl/pingpong_match_ctrl.sv
// Match controller for a two-paddle pong game: start sync, serve/play/point/over FSM, scoring.
// Optional macro PINGPONG_AUTO_SERVE_EN adds an automatic serve after SERVE_FRAMES frame ticks.
module pingpong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int POINT_FRAMES = 60,
  parameter int SERVE_FRAMES = 90,
  parameter int BOARD_W      = 100,
  parameter int BOARD_H      = 20,
  parameter int BALL_SZ      = 16,
  parameter int BOARD2_V     = 580
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] ball_h,
  input  logic [9:0] ball_v,
  input  logic       ball_v_dir,
  input  logic [9:0] board1_h,
  input  logic [9:0] board2_h,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic       bounce_v,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [10:0] BOARD_W_W  = 11'(BOARD_W);
  localparam logic [10:0] BOARD_H_W  = 11'(BOARD_H);
  localparam logic [10:0] BALL_SZ_W  = 11'(BALL_SZ);
  localparam logic [10:0] BOARD2_V_W = 11'(BOARD2_V);
  localparam logic [3:0]  WIN_W      = 4'(WIN_SCORE);
  localparam logic [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);
`ifdef PINGPONG_AUTO_SERVE_EN
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
`else
  logic unused_serve_cfg;
  assign unused_serve_cfg = ^8'(SERVE_FRAMES);
`endif

  state_t     state_q, state_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       bounce_q, bounce_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       sync1_q, sync2_q, sync3_q, start_q;

  // Two-flop synchroniser, then a registered rising-edge detect gives a one-cycle start.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      start_q <= sync2_q & ~sync3_q;
    end
  end

  logic [10:0] ball_h_w, ball_v_w, pad_h_w;
  logic        top_zone, bot_zone, overlap;
  logic [3:0]  scorer_score;

  // Widened to 11 bits so that coordinate + size never wraps near the right/bottom edge.
  assign ball_h_w     = {1'b0, ball_h};
  assign ball_v_w     = {1'b0, ball_v};
  assign pad_h_w      = ball_v_dir ? {1'b0, board2_h} : {1'b0, board1_h};
  assign top_zone     = !ball_v_dir && (ball_v_w <= BOARD_H_W);
  assign bot_zone     = ball_v_dir && ((ball_v_w + BALL_SZ_W) >= BOARD2_V_W);
  assign overlap      = ((ball_h_w + BALL_SZ_W) >= pad_h_w) && (ball_h_w <= (pad_h_w + BOARD_W_W));
  assign scorer_score = serve_dir_q ? score1_q : score2_q;

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    bounce_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        frame_cnt_d = '0;
        if (start_q) begin
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
`ifdef PINGPONG_AUTO_SERVE_EN
        if (start_q) begin
          frame_cnt_d = '0;
          state_d     = ST_PLAY;
        end else if (frame_tick) begin
          if (frame_cnt_q == SERVE_LAST) begin
            frame_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
`else
        if (start_q) begin
          state_d = ST_PLAY;
        end
`endif
      end
      ST_PLAY: begin
        frame_cnt_d = '0;
        if (frame_tick && !start_q && (top_zone || bot_zone)) begin
          if (overlap) begin
            bounce_d = 1'b1;
          end else begin
            // The player opposite the missing paddle scores and receives the next serve direction.
            if (ball_v_dir) begin
              score1_d    = (score1_q == 4'd15) ? 4'd15 : score1_q + 4'd1;
              serve_dir_d = 1'b1;
            end else begin
              score2_d    = (score2_q == 4'd15) ? 4'd15 : score2_q + 4'd1;
              serve_dir_d = 1'b0;
            end
            state_d = ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick && !start_q) begin
          if (frame_cnt_q == POINT_LAST) begin
            frame_cnt_d = '0;
            if (scorer_score >= WIN_W) begin
              winner_d = serve_dir_q ? 2'b01 : 2'b10;
              state_d  = ST_OVER;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        frame_cnt_d = '0;
        if (start_q) begin
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          state_d     = ST_SERVE;
        end
      end
      default: begin
        frame_cnt_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b1;
      bounce_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      bounce_q    <= bounce_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Motion controls decode straight from the state register so reset takes effect at once.
  assign ball_run    = (state_q == ST_PLAY);
  assign ball_center = (state_q != ST_PLAY);
  assign serve_dir   = serve_dir_q;
  assign bounce_v    = bounce_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pingpong_match_ctrl.sv
// Randomised self-checking bench for pingpong_match_ctrl against a rule-level game model.
// Build with PINGPONG_AUTO_SERVE_EN defined to exercise the automatic serve.
module tb_pingpong_match_ctrl;

  localparam int WIN = 2;
  localparam int PF  = 60;
  localparam int SF  = 3;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;

  logic       pixel_clk = 1'b0;
  logic       rst, frame_tick, start_btn, ball_v_dir;
  logic [9:0] ball_h, ball_v, board1_h, board2_h;
  logic       ball_run, ball_center, serve_dir, bounce_v;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int m_state, m_s1, m_s2, m_winner, m_dir;

  pingpong_match_ctrl #(
    .WIN_SCORE(WIN), .POINT_FRAMES(PF), .SERVE_FRAMES(SF),
    .BOARD_W(100), .BOARD_H(20), .BALL_SZ(16), .BOARD2_V(580)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_h(ball_h), .ball_v(ball_v), .ball_v_dir(ball_v_dir),
    .board1_h(board1_h), .board2_h(board2_h),
    .ball_run(ball_run), .ball_center(ball_center), .serve_dir(serve_dir), .bounce_v(bounce_v),
    .score1(score1), .score2(score2), .winner(winner), .state(state)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Game rules: 0 = nothing, 1 = bounce, 2 = player 1 scores, 3 = player 2 scores.
  function automatic int playOutcome(int bh, int bv, int dir, int b1, int b2);
    int pad;
    pad = dir ? b2 : b1;
    if (dir == 0 && bv > 20) return 0;
    if (dir == 1 && bv + 16 < 580) return 0;
    if (bh + 16 >= pad && bh <= pad + 100) return 1;
    return dir ? 2 : 3;
  endfunction

  task automatic checkAll();
    checkOutput("state", state, m_state);
    checkOutput("score1", score1, m_s1);
    checkOutput("score2", score2, m_s2);
    checkOutput("winner", winner, m_winner);
    checkOutput("serve_dir", serve_dir, m_dir);
    checkOutput("ball_run", ball_run, (m_state == S_PLAY) ? 1 : 0);
    if (m_state != S_POINT) checkOutput("ball_center", ball_center, (m_state == S_PLAY) ? 0 : 1);
  endtask

  task automatic resetModel();
    m_state = S_IDLE; m_s1 = 0; m_s2 = 0; m_winner = 0; m_dir = 1;
  endtask

  task automatic resetDut();
    rst = 1'b1; start_btn = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge pixel_clk);
    resetModel();
    checkAll();
    checkOutput("bounce_rst", bounce_v, 0);
    rst = 1'b0;
  endtask

  // Press held from a falling edge: the state changes after exactly the 4th rising edge.
  task automatic pressStart();
    int prev;
    prev = m_state;
    start_btn = 1'b1;
    repeat (3) @(negedge pixel_clk);
    checkOutput("start_latency", state, prev);
    @(negedge pixel_clk);
    start_btn = 1'b0;
    if (prev == S_IDLE || prev == S_OVER) begin
      m_state = S_SERVE; m_s1 = 0; m_s2 = 0; m_winner = 0; m_dir = 1;
    end else if (prev == S_SERVE) begin
      m_state = S_PLAY;
    end
    checkAll();
    repeat (4) @(negedge pixel_clk);
  endtask

  task automatic frameTick();
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    @(negedge pixel_clk);
  endtask

  // One frame tick in PLAY with the given ball and paddle positions.
  task automatic applyStimulus(input int bh, input int bv, input int dir, input int b1, input int b2);
    int outcome;
    ball_h = 10'(bh); ball_v = 10'(bv); ball_v_dir = dir[0];
    board1_h = 10'(b1); board2_h = 10'(b2);
    outcome = playOutcome(bh, bv, dir, b1, b2);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    checkOutput("bounce", bounce_v, (outcome == 1) ? 1 : 0);
    if (outcome == 2) begin
      m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dir = 1; m_state = S_POINT;
    end else if (outcome == 3) begin
      m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dir = 0; m_state = S_POINT;
    end
    checkAll();
    @(negedge pixel_clk);
    if (outcome == 1) checkOutput("bounce_width", bounce_v, 0);
  endtask

  task automatic pointPhase();
    int pts;
    for (int i = 1; i <= PF; i++) begin
      frameTick();
      if (i == PF - 1) checkOutput("point_hold", state, S_POINT);
    end
    pts = m_dir ? m_s1 : m_s2;
    if (pts >= WIN) begin
      m_state = S_OVER; m_winner = m_dir ? 1 : 2;
    end else begin
      m_state = S_SERVE;
    end
    checkAll();
  endtask

  task automatic randomTick();
    int dir, sel, bh, bv, b1, b2, pad;
    dir = int'($urandom_range(0, 1));
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: bv = int'($urandom_range(0, 40));
      1: bv = int'($urandom_range(540, 1023));
      2: bv = dir ? ($urandom_range(0, 1) ? 564 : 563) : ($urandom_range(0, 1) ? 20 : 21);
      default: bv = int'($urandom_range(0, 1023));
    endcase
    bh = int'($urandom_range(0, 1023));
    pad = bh - 110 + int'($urandom_range(0, 140));
    if (pad < 0) pad = 0;
    if (pad > 1023) pad = 1023;
    if ($urandom_range(0, 3) == 0) pad = int'($urandom_range(0, 1023));
    b1 = dir ? int'($urandom_range(0, 1023)) : pad;
    b2 = dir ? pad : int'($urandom_range(0, 1023));
    applyStimulus(bh, bv, dir, b1, b2);
  endtask

  initial begin
    ball_h = '0; ball_v = 10'd300; ball_v_dir = 1'b0; board1_h = '0; board2_h = '0;
    resetDut();
    pressStart();
    pressStart();

    applyStimulus(400, 18, 0, 350, 0);
    applyStimulus(100, 570, 1, 0, 350);
    pointPhase();

    pressStart();
    applyStimulus(0, 10, 0, 500, 0);
    pointPhase();
    pressStart();
    applyStimulus(0, 10, 0, 500, 0);
    pointPhase();
    pressStart();

    pressStart();
    applyStimulus(0, 10, 0, 500, 0);
    repeat (10) frameTick();
    #2 rst = 1'b1;
    #1;
    resetModel();
    checkAll();
    checkOutput("bounce_async_rst", bounce_v, 0);
    @(negedge pixel_clk);
    rst = 1'b0;
    pressStart();

    for (int it = 0; it < 80; it++) begin
      case (m_state)
        S_PLAY:  randomTick();
        S_POINT: pointPhase();
        default: pressStart();
      endcase
    end

    resetDut();
    pressStart();
    frameTick();
    frameTick();
    checkOutput("serve_wait", state, S_SERVE);
    frameTick();
`ifdef PINGPONG_AUTO_SERVE_EN
    m_state = S_PLAY;
`endif
    checkAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
